// File: rtl/eth_nlp_rx_pkg.sv
// Shared types and default timing for the 10BASE-T NLP link-integrity receiver.
// Optional statistics counters are enabled with `define ETH_NLP_RX_STAT_EN.
package eth_nlp_rx_pkg;

    typedef enum logic [1:0] {
        LINK_FAIL = 2'd0,
        LINK_TEST = 2'd1,
        LINK_OK   = 2'd2
    } nlp_rx_state_t;

    // Defaults assume a 90 MHz clock.
    localparam int unsigned PW_MIN_D   = 4;
    localparam int unsigned PW_MAX_D   = 16;
    localparam int unsigned MIN_GAP_D  = 360000;
    localparam int unsigned MAX_GAP_D  = 2250000;
    localparam int unsigned LOSS_CYC_D = 4500000;
    localparam int unsigned GOOD_CNT_D = 4;

endpackage

// File: rtl/eth_nlp_rx_pw.sv
// Synchroniser and pulse-width qualifier for the NLP receiver.
// With `define ETH_NLP_RX_STAT_EN an extra width_rej strobe flags falling edges of bad width.
module eth_nlp_rx_pw
    import eth_nlp_rx_pkg::*;
#(
    parameter int unsigned PW_MIN = PW_MIN_D,
    parameter int unsigned PW_MAX = PW_MAX_D
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_nlp,
    output logic pulse_det
`ifdef ETH_NLP_RX_STAT_EN
    ,
    output logic width_rej
`endif
);

    localparam int unsigned WW = $clog2(PW_MAX + 2);
    localparam logic [WW-1:0] W_SAT = WW'(PW_MAX + 1);
    localparam logic [WW-1:0] W_MIN = WW'(PW_MIN);
    localparam logic [WW-1:0] W_MAX = WW'(PW_MAX);

    logic          rx_m;
    logic          rx_s;
    logic          rx_s_q;
    logic [WW-1:0] w_cnt;
    logic          fall;
    logic          w_ok;

    assign fall = rx_s_q & ~rx_s;
    assign w_ok = (w_cnt >= W_MIN) && (w_cnt <= W_MAX);

    // Two-flop synchroniser, high-time counter and registered qualified strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m      <= 1'b0;
            rx_s      <= 1'b0;
            rx_s_q    <= 1'b0;
            w_cnt     <= '0;
            pulse_det <= 1'b0;
        end else begin
            rx_m   <= rx_nlp;
            rx_s   <= rx_m;
            rx_s_q <= rx_s;
            // Saturate so a stuck-high line can never look like a valid width.
            if (rx_s) begin
                if (w_cnt != W_SAT) w_cnt <= w_cnt + 1'b1;
            end else begin
                w_cnt <= '0;
            end
            pulse_det <= fall && w_ok;
        end
    end

`ifdef ETH_NLP_RX_STAT_EN
    // Strobe for pulses that ended with an out-of-range width.
    always_ff @(posedge clk) begin
        if (reset) width_rej <= 1'b0;
        else       width_rej <= fall && !w_ok;
    end
`endif

endmodule

// File: rtl/eth_nlp_rx.sv
// 10BASE-T link-integrity receiver: pulse spacing checks, link FSM and link_ok output.
// Optional pulse_cnt/rej_cnt statistics are enabled with `define ETH_NLP_RX_STAT_EN.
module eth_nlp_rx
    import eth_nlp_rx_pkg::*;
#(
    parameter int unsigned PW_MIN   = PW_MIN_D,
    parameter int unsigned PW_MAX   = PW_MAX_D,
    parameter int unsigned MIN_GAP  = MIN_GAP_D,
    parameter int unsigned MAX_GAP  = MAX_GAP_D,
    parameter int unsigned LOSS_CYC = LOSS_CYC_D,
    parameter int unsigned GOOD_CNT = GOOD_CNT_D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_nlp,
    input  logic        rx_active,
    output logic        pulse_det,
    output logic        link_ok,
    output logic [31:0] c_out
`ifdef ETH_NLP_RX_STAT_EN
    ,
    output logic [15:0] pulse_cnt,
    output logic [15:0] rej_cnt
`endif
);

    nlp_rx_state_t state;
    logic [31:0]   gap;
    logic [3:0]    good;
    logic          early;
    logic          late;
    logic          gap_sat;
    logic          accept;

`ifdef ETH_NLP_RX_STAT_EN
    logic width_rej;
    logic early_rej;
`endif

    eth_nlp_rx_pw #(
        .PW_MIN (PW_MIN),
        .PW_MAX (PW_MAX)
    ) u_pw (
        .clk       (clk),
        .reset     (reset),
        .rx_nlp    (rx_nlp),
        .pulse_det (pulse_det)
`ifdef ETH_NLP_RX_STAT_EN
        ,
        .width_rej (width_rej)
`endif
    );

    assign early   = gap < 32'(MIN_GAP);
    assign late    = gap > 32'(MAX_GAP);
    assign gap_sat = gap == 32'(LOSS_CYC);
    assign c_out   = gap;

    // A pulse is accepted (and restarts the gap timer) unless it loses to a timeout or is early in LINK_OK.
    always_comb begin
        accept = 1'b0;
        unique case (state)
            LINK_FAIL: accept = pulse_det;
            LINK_TEST: accept = pulse_det && !late;
            LINK_OK:   accept = pulse_det && !early;
            default:   accept = 1'b0;
        endcase
    end

    // Gap timer: cleared by accepted pulses, or by frame activity while the link is up.
    always_ff @(posedge clk) begin
        if (reset)                             gap <= '0;
        else if (accept)                       gap <= '0;
        else if (state == LINK_OK && rx_active) gap <= '0;
        else if (!gap_sat)                     gap <= gap + 32'd1;
    end

    // Link FSM; pulse_det is already registered, so the state follows it by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LINK_FAIL;
            good    <= '0;
            link_ok <= 1'b0;
        end else begin
            unique case (state)
                LINK_FAIL: begin
                    if (pulse_det) begin
                        state <= LINK_TEST;
                        good  <= 4'd1;
                    end
                end
                LINK_TEST: begin
                    if (pulse_det && !late) begin
                        if (early) begin
                            good <= 4'd1;
                        end else begin
                            good <= good + 4'd1;
                            if (good + 4'd1 == 4'(GOOD_CNT)) begin
                                state   <= LINK_OK;
                                link_ok <= 1'b1;
                            end
                        end
                    end else if (late) begin
                        state <= LINK_FAIL;
                        good  <= '0;
                    end
                end
                LINK_OK: begin
                    if (gap_sat && !accept) begin
                        state   <= LINK_FAIL;
                        good    <= '0;
                        link_ok <= 1'b0;
                    end
                end
                default: begin
                    state   <= LINK_FAIL;
                    good    <= '0;
                    link_ok <= 1'b0;
                end
            endcase
        end
    end

`ifdef ETH_NLP_RX_STAT_EN
    assign early_rej = pulse_det && early && (state == LINK_TEST || state == LINK_OK);

    // Wrapping statistics: good pulses versus width-rejected or early pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_cnt <= '0;
            rej_cnt   <= '0;
        end else begin
            if (accept && !early_rej)    pulse_cnt <= pulse_cnt + 16'd1;
            if (width_rej || early_rej)  rej_cnt   <= rej_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_nlp_rx.sv
// Directed self-checking bench for eth_nlp_rx with shortened timing parameters.
// Builds with or without `define ETH_NLP_RX_STAT_EN.
module tb_eth_nlp_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_nlp;
    logic        rx_active;
    logic        pulse_det;
    logic        link_ok;
    logic [31:0] c_out;
`ifdef ETH_NLP_RX_STAT_EN
    logic [15:0] pulse_cnt;
    logic [15:0] rej_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int c0     = 0;
    int unsigned lo;

    eth_nlp_rx #(
        .PW_MIN   (4),
        .PW_MAX   (16),
        .MIN_GAP  (100),
        .MAX_GAP  (400),
        .LOSS_CYC (800),
        .GOOD_CNT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_nlp    (rx_nlp),
        .rx_active (rx_active),
        .pulse_det (pulse_det),
        .link_ok   (link_ok),
        .c_out     (c_out)
`ifdef ETH_NLP_RX_STAT_EN
        ,
        .pulse_cnt (pulse_cnt),
        .rej_cnt   (rej_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Free-running cycle count; the expected gap is derived from it.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_nlp(input int w);
        rx_nlp = 1'b1;
        tick(w);
        rx_nlp = 1'b0;
    endtask

    // Poll a bounded number of cycles; returns on the cycle pulse_det is seen.
    task automatic wait_pd(output bit s);
        s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pulse_det === 1'b1) begin
                s = 1'b1;
                break;
            end
        end
    endtask

    task automatic nlp_ok(input string tag, input int w);
        bit s;
        send_nlp(w);
        wait_pd(s);
        check_eq(tag, 32'(s), 32'd1);
    endtask

    task automatic nlp_rej(input string tag, input int w);
        bit s;
        send_nlp(w);
        wait_pd(s);
        check_eq(tag, 32'(s), 32'd0);
        tick(5);
    endtask

    // Three in-window pulses from LINK_FAIL; link_ok must rise only after the third.
    task automatic bring_up(input string tag, input int w0, input int w1, input int w2);
        for (int k = 0; k < 3; k++) begin
            nlp_ok({tag, "_pd"}, (k == 0) ? w0 : (k == 1) ? w1 : w2);
            check_eq({tag, "_pre"}, 32'(link_ok), 32'd0);
            tick(1);
            check_eq({tag, "_gapclr"}, c_out, 32'd0);
            check_eq({tag, "_link"}, 32'(link_ok), (k == 2) ? 32'd1 : 32'd0);
            if (k < 2) tick(195);
        end
        c0 = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        rx_nlp    = 1'b0;
        rx_active = 1'b0;
        tick(3);
        check_eq("rst_link", 32'(link_ok), 32'd0);
        check_eq("rst_gap", c_out, 32'd0);
        check_eq("rst_pd", 32'(pulse_det), 32'd0);
        reset = 1'b0;

        // Bad widths never qualify.
        nlp_rej("w2", 2);
        nlp_rej("w3", 3);
        nlp_rej("w17", 17);
        nlp_rej("w20", 20);
        check_eq("bad_w_link", 32'(link_ok), 32'd0);

        // Three 8-cycle pulses about 200 cycles apart; also one-cycle strobe check.
        nlp_ok("t1_first", 8);
        tick(1);
        check_eq("t1_strobe1", 32'(pulse_det), 32'd0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        bring_up("t1", 8, 8, 8);

        // Early pulse in LINK_OK is ignored, then loss timeout at 800.
        tick(40);
        nlp_ok("t3_pd", 8);
        tick(1);
        check_eq("t3_gap_kept", c_out, 32'(cyc - c0));
        check_eq("t3_link", 32'(link_ok), 32'd1);
        while (cyc - c0 < 800) tick(1);
        check_eq("t3_gap800", c_out, 32'd800);
        check_eq("t3_link800", 32'(link_ok), 32'd1);
        tick(1);
        check_eq("t3_drop", 32'(link_ok), 32'd0);
        check_eq("t3_gapsat", c_out, 32'd800);

        // rx_active refresh keeps the link up with no pulses.
        bring_up("t5", 8, 8, 8);
        lo = 1;
        for (int i = 0; i < 9; i++) begin
            rx_active = 1'b1;
            tick(1);
            rx_active = 1'b0;
            if (i == 0) check_eq("t5_clr", c_out, 32'd0);
            for (int j = 0; j < 599; j++) begin
                tick(1);
                if (link_ok !== 1'b1) lo = 0;
            end
        end
        check_eq("t5_hold", lo, 32'd1);
        check_eq("t5_gap", c_out, 32'd599);

        // Reset while up drops the link; boundary widths 4 and 16 recover it.
        check_eq("t6_up", 32'(link_ok), 32'd1);
        reset = 1'b1;
        tick(1);
        check_eq("t6_link", 32'(link_ok), 32'd0);
        check_eq("t6_gap", c_out, 32'd0);
        reset = 1'b0;
        bring_up("t6", 4, 16, 8);

        // LINK_TEST timeout at gap 401, then a full three-pulse bring-up is needed.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        nlp_ok("t4_pd1", 8);
        tick(1);
        c0 = cyc;
        check_eq("t4_gapclr", c_out, 32'd0);
        while (cyc - c0 < 401) tick(1);
        check_eq("t4_gap401", c_out, 32'd401);
        check_eq("t4_link", 32'(link_ok), 32'd0);
        tick(90);
        bring_up("t4", 8, 8, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
